// File: rtl/dmac_channel_arbiter_if.sv
// Handshake bundle between the DMAC channel arbiter, the peripherals, the AHB
// system arbiter and the DMAC datapath.
interface dmac_channel_arbiter_if;
  logic [1:0] DmacReq;
  logic       C_config;
  logic       irq;
  logic       con_new_sel;
  logic       Bus_Grant;
  logic       Bus_Req;
  logic       channel_en_1;
  logic       channel_en_2;
  logic       con_en;
  logic       con_sel;
  logic [1:0] ReqAck;
  logic       Grant_Err;

  modport master (
    input  DmacReq, C_config, irq, con_new_sel, Bus_Grant,
    output Bus_Req, channel_en_1, channel_en_2, con_en, con_sel, ReqAck, Grant_Err
  );

  modport slave (
    output DmacReq, C_config, irq, con_new_sel, Bus_Grant,
    input  Bus_Req, channel_en_1, channel_en_2, con_en, con_sel, ReqAck, Grant_Err
  );
endinterface

// File: rtl/dmac_channel_arbiter.sv
// Two-requester DMA channel arbiter: picks a channel, obtains the AHB bus,
// enables the datapath channel while granted and acknowledges on completion.
module dmac_channel_arbiter #(
  parameter bit RR_EN         = 1'b0,
  parameter int GRANT_TIMEOUT = 64,
  parameter int CNT_W         = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  dmac_channel_arbiter_if.master  io_arb
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_REQ = 2'd1,
    ST_XFER    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_con_en;
  logic             r_bus_req;
  logic             r_en_1;
  logic             r_en_2;
  logic [1:0]       r_ack;
  logic             r_gerr;

  logic             w_winner;
  logic             w_timeout;

  // Round-robin alternates against the datapath's copy of the last latched select.
  always_comb begin
    w_winner = 1'b0;
    if ((RR_EN != 1'b0) && (io_arb.DmacReq == 2'b11)) begin
      w_winner = ~io_arb.con_new_sel;
    end else if (io_arb.DmacReq[0]) begin
      w_winner = 1'b0;
    end else begin
      w_winner = 1'b1;
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(GRANT_TIMEOUT - 1));

  // Transfer sequencing; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_con_en  <= 1'b0;
      r_bus_req <= 1'b0;
      r_en_1    <= 1'b0;
      r_en_2    <= 1'b0;
      r_ack     <= 2'b00;
      r_gerr    <= 1'b0;
    end else begin
      r_con_en <= 1'b0;
      r_ack    <= 2'b00;
      r_gerr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bus_req <= 1'b0;
          r_en_1    <= 1'b0;
          r_en_2    <= 1'b0;
          r_cnt     <= '0;
          if (io_arb.C_config && (io_arb.DmacReq != 2'b00)) begin
            r_sel    <= w_winner;
            r_con_en <= 1'b1;
            r_state  <= ST_BUS_REQ;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_BUS_REQ: begin
          // The first cycle here only raises Bus_Req; grant/timeout count from then on.
          r_bus_req <= 1'b1;
          if (r_bus_req && io_arb.Bus_Grant) begin
            r_state <= ST_XFER;
            r_cnt   <= '0;
            r_en_1  <= ~r_sel;
            r_en_2  <= r_sel;
          end else if (r_bus_req && w_timeout) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bus_req <= 1'b0;
            r_gerr    <= 1'b1;
          end else if (r_bus_req) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        ST_XFER: begin
          if (io_arb.irq) begin
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            r_en_1    <= 1'b0;
            r_en_2    <= 1'b0;
            r_ack     <= r_sel ? 2'b10 : 2'b01;
          end else begin
            r_state <= ST_XFER;
            r_en_1  <= io_arb.Bus_Grant & ~r_sel;
            r_en_2  <= io_arb.Bus_Grant & r_sel;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_en_1    <= 1'b0;
          r_en_2    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_bus_req <= 1'b0;
          r_en_1    <= 1'b0;
          r_en_2    <= 1'b0;
        end
      endcase
    end
  end

  assign io_arb.Bus_Req      = r_bus_req;
  assign io_arb.channel_en_1 = r_en_1;
  assign io_arb.channel_en_2 = r_en_2;
  assign io_arb.con_en       = r_con_en;
  assign io_arb.con_sel      = r_sel;
  assign io_arb.ReqAck       = r_ack;
  assign io_arb.Grant_Err    = r_gerr;

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// Bench for dmac_channel_arbiter: a fixed-priority and a round-robin instance
// share stimulus; a scoreboard of expected selects/acks is checked by monitors.
module tb_dmac_channel_arbiter;

  typedef struct packed {
    logic sel;
    logic abort;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       cfg;
  logic       irq;
  logic       bg;
  logic       nsel_f;
  logic       nsel_r;
  logic       exp_sel_f;
  logic       exp_sel_r;
  logic       last_r;
  int         n_chk;
  int         n_pass;
  exp_t       q_f[$];
  exp_t       q_r[$];

  dmac_channel_arbiter_if if_f ();
  dmac_channel_arbiter_if if_r ();

  assign if_f.DmacReq     = req;
  assign if_f.C_config    = cfg;
  assign if_f.irq         = irq;
  assign if_f.Bus_Grant   = bg;
  assign if_f.con_new_sel = nsel_f;
  assign if_r.DmacReq     = req;
  assign if_r.C_config    = cfg;
  assign if_r.irq         = irq;
  assign if_r.Bus_Grant   = bg;
  assign if_r.con_new_sel = nsel_r;

  dmac_channel_arbiter #(.RR_EN(1'b0), .GRANT_TIMEOUT(8), .CNT_W(4)) u_fix (
    .clk    (clk),
    .rst    (rst),
    .io_arb (if_f.master)
  );

  dmac_channel_arbiter #(.RR_EN(1'b1), .GRANT_TIMEOUT(8), .CNT_W(4)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .io_arb (if_r.master)
  );

  logic [7:0] out_f;
  logic [7:0] out_r;
  logic [1:0] en_f;
  assign out_f = {if_f.Bus_Req, if_f.channel_en_1, if_f.channel_en_2, if_f.con_en,
                  if_f.con_sel, if_f.ReqAck, if_f.Grant_Err};
  assign out_r = {if_r.Bus_Req, if_r.channel_en_1, if_r.channel_en_2, if_r.con_en,
                  if_r.con_sel, if_r.ReqAck, if_r.Grant_Err};
  assign en_f  = {if_f.channel_en_2, if_f.channel_en_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: latches the select on con_en.
  always @(posedge clk) begin
    if (rst) begin
      nsel_f <= 1'b0;
      nsel_r <= 1'b0;
    end else begin
      if (if_f.con_en) nsel_f <= if_f.con_sel;
      if (if_r.con_en) nsel_r <= if_r.con_sel;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected selection per instance from the request pattern at arbitration time.
  task automatic push(input bit abort);
    exp_t e;
    exp_sel_f = req[0] ? 1'b0 : 1'b1;
    if (req == 2'b11) exp_sel_r = ~last_r;
    else              exp_sel_r = exp_sel_f;
    last_r  = exp_sel_r;
    e.abort = abort;
    e.sel   = exp_sel_f;
    q_f.push_back(e);
    e.sel   = exp_sel_r;
    q_r.push_back(e);
  endtask

  task automatic mon(input bit which, input logic ce, input logic cs, input logic [1:0] ack,
                     input logic ge, input logic e1, input logic e2);
    exp_t  e;
    int    depth;
    string tag;
    tag   = which ? "rr" : "fix";
    depth = which ? q_r.size() : q_f.size();
    chk({tag, "_en_excl"}, 8'(e1 & e2), 8'd0);
    if (ce || (ack != 2'b00) || ge) begin
      chk({tag, "_sb_depth"}, 8'(depth > 0), 8'd1);
      if (depth > 0) begin
        e = which ? q_r[0] : q_f[0];
        if (ce) chk({tag, "_con_sel"}, 8'(cs), 8'(e.sel));
        if ((ack != 2'b00) || ge) begin
          if (which) void'(q_r.pop_front());
          else       void'(q_f.pop_front());
          chk({tag, "_ack"}, 8'(ack), e.abort ? 8'd0 : (e.sel ? 8'd2 : 8'd1));
          chk({tag, "_gerr"}, 8'(ge), 8'(e.abort));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(1'b0, if_f.con_en, if_f.con_sel, if_f.ReqAck, if_f.Grant_Err,
          if_f.channel_en_1, if_f.channel_en_2);
      mon(1'b1, if_r.con_en, if_r.con_sel, if_r.ReqAck, if_r.Grant_Err,
          if_r.channel_en_1, if_r.channel_en_2);
    end
  end

  // One transfer from IDLE; gwait >= 8 withholds the grant for the whole window.
  task automatic xfer(input int gwait, input int nx, input int stall_at, input int stall_len,
                      input bit drop);
    logic [1:0] en_exp;
    int         n;
    int         guard;
    push(gwait >= 8);
    en_exp = exp_sel_f ? 2'b10 : 2'b01;
    tick;
    chk("con_en", 8'(if_f.con_en), 8'd1);
    chk("breq_latency", 8'(if_f.Bus_Req), 8'd0);
    if (drop) begin
      req = 2'b00;
      cfg = 1'b0;
    end
    bg = 1'b0;
    tick;
    chk("breq_on", 8'(if_f.Bus_Req), 8'd1);
    chk("con_en_pulse", 8'(if_f.con_en), 8'd0);
    if (gwait >= 8) begin
      n     = 1;
      guard = 0;
      while (if_f.Bus_Req && (guard < 20)) begin
        tick;
        guard++;
        if (if_f.Bus_Req) n++;
      end
      chk("to_breq_cycles", 8'(n), 8'd8);
      chk("to_gerr", 8'(if_f.Grant_Err), 8'd1);
      chk("to_ack", 8'(if_f.ReqAck), 8'd0);
      tick;
      chk("to_gerr_pulse", 8'(if_f.Grant_Err), 8'd0);
      chk("to_idle", 8'(if_f.Bus_Req), 8'd0);
    end else begin
      repeat (gwait) begin
        tick;
        chk("wait_breq", 8'(if_f.Bus_Req), 8'd1);
        chk("wait_en", 8'(en_f), 8'd0);
      end
      bg = 1'b1;
      tick;
      chk("grant_en", 8'(en_f), 8'(en_exp));
      for (int i = 0; i < nx; i++) begin
        if (i == stall_at) begin
          bg = 1'b0;
          repeat (stall_len) begin
            tick;
            chk("stall_en", 8'(en_f), 8'd0);
            chk("stall_breq", 8'(if_f.Bus_Req), 8'd1);
          end
          bg = 1'b1;
        end
        tick;
        chk("xfer_en", 8'(en_f), 8'(en_exp));
        chk("xfer_sel", 8'(if_f.con_sel), 8'(exp_sel_f));
      end
      irq = 1'b1;
      tick;
      irq = 1'b0;
      bg  = 1'b0;
      chk("done_en", 8'(en_f), 8'd0);
      chk("done_breq", 8'(if_f.Bus_Req), 8'd0);
      chk("done_ack", 8'(if_f.ReqAck), 8'(en_exp));
      tick;
      chk("ack_pulse", 8'(if_f.ReqAck), 8'd0);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    last_r = 1'b0;
    rst = 1'b1; req = 2'b11; cfg = 1'b1; irq = 1'b0; bg = 1'b0;
    repeat (3) tick;
    chk("rst_fix", out_f, 8'd0);
    chk("rst_rr", out_r, 8'd0);
    req = 2'b00;
    rst = 1'b0;
    tick;
    chk("rst_idle", out_f, 8'd0);

    cfg = 1'b1; req = 2'b01;
    xfer(3, 10, -1, 0, 1'b1);

    cfg = 1'b0; req = 2'b11;
    repeat (3) begin
      tick;
      chk("cfg_off_fix", out_f & 8'hF7, 8'd0);
      chk("cfg_off_rr", out_r & 8'hF7, 8'd0);
    end

    cfg = 1'b1; req = 2'b11;
    xfer(0, 2, -1, 0, 1'b0);
    xfer(1, 2, -1, 0, 1'b0);
    xfer(0, 2, -1, 0, 1'b1);

    cfg = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) xfer(0, 1, -1, 0, (k == 3));

    cfg = 1'b1; req = 2'b10;
    xfer(2, 3, -1, 0, 1'b1);

    cfg = 1'b1; req = 2'b01;
    xfer(8, 0, -1, 0, 1'b1);

    cfg = 1'b1; req = 2'b01;
    xfer(7, 2, -1, 0, 1'b1);

    cfg = 1'b1; req = 2'b01;
    xfer(1, 6, 2, 4, 1'b1);

    cfg = 1'b1; req = 2'b10;
    push(1'b0);
    tick;
    tick;
    bg = 1'b1;
    tick;
    chk("rst_xfer_en", 8'(en_f), 8'd2);
    tick;
    rst = 1'b1;
    tick;
    chk("rst_mid_fix", out_f, 8'd0);
    chk("rst_mid_rr", out_r, 8'd0);
    q_f.delete();
    q_r.delete();
    last_r = 1'b0;
    rst = 1'b0; req = 2'b00; bg = 1'b0;
    tick;
    chk("rst_mid_idle", out_f, 8'd0);

    tick;
    chk("sb_drain_fix", 8'(q_f.size()), 8'd0);
    chk("sb_drain_rr", 8'(q_r.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
